// File: rtl/semaforo_timer.sv
// Step timer for the traffic-light sequencer: counts `data` steps of TICK_DIV cycles, pulses FIN.
// Optional `remaining` port enabled by defining SEMAFORO_TIMER_REMAIN_EN.
module semaforo_timer #(
   parameter int unsigned TICK_DIV = 50000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       INICIO,
   input  logic [3:0] data,
   output logic       FIN,
   output logic       busy
`ifdef SEMAFORO_TIMER_REMAIN_EN
   ,
   output logic [3:0] remaining
`endif
);

   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

   state_t        state;
   logic [PW-1:0] prescaler;
   logic [3:0]    counter;
   logic          inicioQ;

   // Abort (INICIO low) is checked before any tick so it wins over the final step.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         prescaler <= '0;
         counter   <= 4'd0;
         inicioQ   <= 1'b0;
         FIN       <= 1'b0;
         busy      <= 1'b0;
      end else begin
         inicioQ <= INICIO;
         FIN     <= 1'b0;
         case (state)
            IDLE: begin
               if (INICIO && !inicioQ) begin
                  state     <= COUNT;
                  busy      <= 1'b1;
                  counter   <= data;
                  prescaler <= '0;
               end
            end
            COUNT: begin
               if (!INICIO) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  prescaler <= '0;
                  counter   <= 4'd0;
               end else if (counter == 4'd0) begin
                  state     <= DONE;
                  busy      <= 1'b0;
                  FIN       <= 1'b1;
                  prescaler <= '0;
               end else if (prescaler == LAST) begin
                  prescaler <= '0;
                  if (counter == 4'd1) begin
                     counter <= 4'd0;
                     state   <= DONE;
                     busy    <= 1'b0;
                     FIN     <= 1'b1;
                  end else begin
                     counter <= counter - 4'd1;
                  end
               end else begin
                  prescaler <= prescaler + PW'(1);
               end
            end
            DONE: begin
               if (!INICIO) state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef SEMAFORO_TIMER_REMAIN_EN
   assign remaining = counter;
`endif

endmodule

// File: tb/tb_semaforo_timer.sv
// Directed bench for semaforo_timer with TICK_DIV=4; cycle 0 is the first cycle after reset.
module tb_semaforo_timer;

   logic       clk = 1'b0;
   logic       rst;
   logic       INICIO;
   logic [3:0] data;
   logic       FIN;
   logic       busy;
`ifdef SEMAFORO_TIMER_REMAIN_EN
   logic [3:0] remaining;
`endif

   int total = 0;
   int bad   = 0;

   semaforo_timer #(.TICK_DIV(4)) dut (
      .clk(clk),
      .rst(rst),
      .INICIO(INICIO),
      .data(data),
      .FIN(FIN),
      .busy(busy)
`ifdef SEMAFORO_TIMER_REMAIN_EN
      ,
      .remaining(remaining)
`endif
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   // Samples outputs mid-cycle, then advances to just after the next rising edge.
   task automatic cycleChk(input string sc, input int c, input logic expFin,
                           input logic expBusy, input int expRem);
      @(negedge clk);
      checkVal($sformatf("%s c%0d fin", sc, c), 32'(FIN), 32'(expFin));
      checkVal($sformatf("%s c%0d busy", sc, c), 32'(busy), 32'(expBusy));
`ifdef SEMAFORO_TIMER_REMAIN_EN
      if (expRem >= 0)
         checkVal($sformatf("%s c%0d rem", sc, c), 32'(remaining), 32'(expRem));
`endif
      @(posedge clk);
      #1;
   endtask

   task automatic resetSeq();
      rst    = 1'b1;
      INICIO = 1'b0;
      data   = 4'd0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) cycleChk("rst", i, 1'b0, 1'b0, 0);
      rst = 1'b0;
   endtask

   initial begin
      int rem;

      // data=3 rising at 10, data changes mid-count
      resetSeq();
      for (int c = 0; c <= 35; c++) begin
         INICIO = (c >= 10);
         data   = (c >= 12) ? 4'd9 : 4'd3;
         if (c >= 11 && c <= 14) rem = 3;
         else if (c >= 15 && c <= 18) rem = 2;
         else if (c >= 19 && c <= 22) rem = 1;
         else rem = 0;
         cycleChk("s30", c, c == 23, c >= 11 && c <= 22, rem);
      end

      // data=0: FIN two cycles after start
      resetSeq();
      for (int c = 0; c <= 14; c++) begin
         INICIO = (c >= 5);
         data   = 4'd0;
         cycleChk("s31", c, c == 7, c == 6, 0);
      end

      // abort then restart
      resetSeq();
      for (int c = 0; c <= 24; c++) begin
         INICIO = (c <= 5) || (c >= 9);
         data   = 4'd2;
         cycleChk("s32", c, c == 18, (c >= 1 && c <= 6) || (c >= 10 && c <= 17), -1);
      end

      // minimum restart gap after FIN
      resetSeq();
      for (int c = 0; c <= 22; c++) begin
         INICIO = (c != 6);
         data   = (c < 7) ? 4'd1 : 4'd2;
         cycleChk("s33", c, c == 5 || c == 16, (c >= 1 && c <= 4) || (c >= 8 && c <= 15), -1);
      end

      // abort coincides with final tick: no FIN
      resetSeq();
      for (int c = 0; c <= 10; c++) begin
         INICIO = (c <= 3);
         data   = 4'd1;
         cycleChk("s19", c, 1'b0, c >= 1 && c <= 4, (c >= 1 && c <= 4) ? 1 : 0);
      end

      // reset mid-count with INICIO held high restarts
      resetSeq();
      for (int c = 0; c <= 36; c++) begin
         INICIO = 1'b1;
         data   = 4'd5;
         rst    = (c == 8);
         cycleChk("s34", c, c == 30, (c >= 1 && c <= 8) || (c >= 10 && c <= 29),
                  (c == 9) ? 0 : -1);
      end
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
